// File: rtl/core_lsu.sv
// Load/store unit: one byte-enabled bus transaction at a time, with lane steering,
// load sign/zero extension, alignment fault detection and a bus-ack timeout.
module core_lsu #(
    parameter int WAIT_MAX = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        MISALIGN,
    output logic        ERR,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [3:0]  BUS_BE,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // counter runs 0..WAIT_MAX-1 across the request cycles; the last value ends the wait
    localparam logic [15:0] CNT_LAST = 16'(WAIT_MAX - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        we_q, we_n, uns_q, uns_n;
    logic [1:0]  size_q, size_n, k_q, k_n;

    logic        busy_n, done_n, mis_n, err_n, req_n, bwe_n;
    logic [31:0] rdata_n, baddr_n, bwd_n, shifted, load_val;
    logic [3:0]  bbe_n, be_in;
    logic [31:0] wd_in;
    logic        bad_align;

    always_comb begin
        bad_align = (SIZE == 2'd3) || (SIZE == 2'd1 && ADDR[0]) ||
                    (SIZE == 2'd2 && ADDR[1:0] != 2'd0);
        case (SIZE)
            2'd0:    begin be_in = 4'b0001 << ADDR[1:0]; wd_in = {4{WDATA[7:0]}};  end
            2'd1:    begin be_in = 4'b0011 << ADDR[1:0]; wd_in = {2{WDATA[15:0]}}; end
            default: begin be_in = 4'hF;                 wd_in = WDATA;            end
        endcase
    end

    // bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted = BUS_RDATA >> {k_q, 3'b000};
        case (size_q)
            2'd0:    load_val = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
            2'd1:    load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = BUS_RDATA;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = we_q;
        uns_n   = uns_q;
        size_n  = size_q;
        k_n     = k_q;
        busy_n  = BUSY;
        done_n  = 1'b0;
        mis_n   = 1'b0;
        err_n   = 1'b0;
        rdata_n = RDATA;
        req_n   = BUS_REQ;
        bwe_n   = BUS_WE;
        baddr_n = BUS_ADDR;
        bbe_n   = BUS_BE;
        bwd_n   = BUS_WDATA;
        case (state)
            IDLE: begin
                if (REQ) begin
                    we_n    = WE;
                    uns_n   = UNS;
                    size_n  = SIZE;
                    k_n     = ADDR[1:0];
                    baddr_n = {ADDR[31:2], 2'b00};
                    busy_n  = 1'b1;
                    if (bad_align) begin
                        state_n = RESP;
                        done_n  = 1'b1;
                        mis_n   = 1'b1;
                    end else begin
                        state_n = ACCESS;
                        cnt_n   = 16'd0;
                        req_n   = 1'b1;
                        bwe_n   = WE;
                        bbe_n   = be_in;
                        bwd_n   = wd_in;
                    end
                end
            end
            ACCESS: begin
                if (BUS_ACK || cnt == CNT_LAST) begin
                    state_n = RESP;
                    done_n  = 1'b1;
                    req_n   = 1'b0;
                    bwe_n   = 1'b0;
                    bbe_n   = 4'h0;
                    bwd_n   = 32'h0;
                    if (BUS_ACK) begin
                        if (!we_q) rdata_n = load_val;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'd0;
            k_q       <= 2'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            MISALIGN  <= 1'b0;
            ERR       <= 1'b0;
            RDATA     <= 32'h0;
            BUS_REQ   <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_ADDR  <= 32'h0;
            BUS_BE    <= 4'h0;
            BUS_WDATA <= 32'h0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            we_q      <= we_n;
            uns_q     <= uns_n;
            size_q    <= size_n;
            k_q       <= k_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            MISALIGN  <= mis_n;
            ERR       <= err_n;
            RDATA     <= rdata_n;
            BUS_REQ   <= req_n;
            BUS_WE    <= bwe_n;
            BUS_ADDR  <= baddr_n;
            BUS_BE    <= bbe_n;
            BUS_WDATA <= bwd_n;
        end
    end
endmodule

// File: tb/tb_core_lsu.sv
// Randomized scoreboard bench for core_lsu: a driver/bus responder issues accesses and
// pushes model expectations; a monitor pops and compares at every DONE.
module tb_core_lsu;
    localparam int WM = 4;

    logic        CLK = 0, RST_N = 0;
    logic        REQ = 0, WE = 0, UNS = 0, BUS_ACK = 0;
    logic [1:0]  SIZE = 0;
    logic [31:0] ADDR = 0, WDATA = 0, BUS_RDATA = 0;
    logic        BUSY, DONE, MISALIGN, ERR, BUS_REQ, BUS_WE;
    logic [31:0] RDATA, BUS_ADDR, BUS_WDATA;
    logic [3:0]  BUS_BE;

    core_lsu #(.WAIT_MAX(WM)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNS(UNS),
        .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA),
        .MISALIGN(MISALIGN), .ERR(ERR), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE),
        .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE), .BUS_WDATA(BUS_WDATA),
        .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          issue;
        int          lat;
        logic        mis;
        logic        err;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [31:0] model_rdata = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Reference model: bytes covered, lane contents and load result from plain arithmetic.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input int d, input logic [31:0] rd);
        exp_t e;
        int k, nb;
        longint v;
        k  = int'(addr % 4);
        nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        e.issue = cyc;
        e.we    = we;
        e.baddr = addr - addr % 4;
        e.mis   = (sz == 3) || (k % nb != 0);
        e.err   = !e.mis && d > WM;
        e.lat   = e.mis ? 1 : e.err ? WM + 1 : d + 1;
        for (int i = 0; i < 4; i++) begin
            e.be[i]        = (i >= k) && (i < k + nb);
            e.bwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        if (!e.mis && !e.err && !we) begin
            if (nb == 4) model_rdata = rd;
            else begin
                v = (longint'(rd) / (longint'(1) << (8*k))) % (longint'(1) << (8*nb));
                if (!uns && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
                model_rdata = v[31:0];
            end
        end
        e.rdata = model_rdata;
        return e;
    endfunction

    // One access starting at a negedge in IDLE; returns at the negedge after DONE.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int d, input logic [31:0] rd);
        exp_t e;
        int   n, guard;
        chk("busy_before_req", BUSY, 0);
        e = model(we, sz, uns, addr, wd, d, rd);
        sb.push_back(e);
        REQ = 1; WE = we; SIZE = sz; UNS = uns; ADDR = addr; WDATA = wd;
        BUS_ACK = 1'($urandom % 2); BUS_RDATA = $urandom;
        @(negedge CLK);
        REQ = 0; WE = 1'($urandom % 2); ADDR = $urandom; WDATA = $urandom;
        n = 0; guard = 0;
        while (!DONE && guard < WM + 20) begin
            if (BUS_REQ) begin
                n++;
                chk("bus_we", BUS_WE, e.we);
                chk("bus_addr", BUS_ADDR, e.baddr);
                chk("bus_be", BUS_BE, e.be);
                chk("bus_wdata", BUS_WDATA, e.bwd);
                BUS_ACK   = (n == d);
                BUS_RDATA = (n == d) ? rd : $urandom;
            end else begin
                chk("bus_idle_fields", {BUS_WE, BUS_BE, BUS_WDATA}, 0);
                BUS_ACK = 1'($urandom % 2); BUS_RDATA = $urandom;
            end
            @(negedge CLK);
            guard++;
        end
        chk("done_within_bound", DONE, 1);
        chk("bus_req_cycles", n, e.mis ? 0 : e.err ? WM : d);
        // REQ coinciding with DONE must be ignored
        REQ = 1'($urandom % 2); SIZE = 2'($urandom); ADDR = $urandom;
        BUS_ACK = 0;
        @(negedge CLK);
        REQ = 0;
    endtask

    // Monitor: every DONE is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (DONE) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got DONE with no access pending (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - e.issue, e.lat);
                    chk("misalign", MISALIGN, e.mis);
                    chk("err", ERR, e.err);
                    chk("rdata", RDATA, e.rdata);
                    chk("busy_at_done", BUSY, 1);
                    chk("bus_req_at_done", BUS_REQ, 0);
                end
            end else begin
                chk("flags_without_done", {MISALIGN, ERR}, 0);
            end
        end
    end

    initial begin
        int reqs;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {BUSY, DONE, MISALIGN, ERR, BUS_REQ, BUS_WE, BUS_BE}, 0);
        chk("reset_data", {RDATA, BUS_ADDR}, 0);
        chk("reset_wdata", BUS_WDATA, 0);
        RST_N = 1;
        @(negedge CLK);

        // directed cases
        txn(0, 0, 0, 32'h103, 32'h0, 1, 32'h80AABBCC);
        txn(0, 0, 1, 32'h103, 32'h0, 1, 32'h80AABBCC);
        txn(1, 1, 0, 32'h22, 32'h1234ABCD, 4, 32'h0);
        txn(0, 2, 0, 32'h41, 32'h0, 1, 32'h0);
        txn(0, 3, 0, 32'h40, 32'h0, 1, 32'h0);
        txn(0, 2, 0, 32'h200, 32'h0, WM + 5, 32'h0);
        txn(0, 2, 0, 32'h200, 32'h0, WM, 32'hCAFEF00D);
        txn(0, 1, 0, 32'h302, 32'h0, 2, 32'h9ABC0000);

        // random traffic
        for (int t = 0; t < 200; t++)
            txn(1'($urandom % 2), 2'($urandom % 8 == 0 ? 3 : $urandom % 3), 1'($urandom % 2),
                $urandom, $urandom, int'($urandom_range(1, WM + 2)), $urandom);

        // REQ held high, immediate ack: one access per 3 cycles
        reqs = 0;
        REQ = 1; WE = 0; SIZE = 2; UNS = 0; ADDR = 32'h40; BUS_RDATA = 32'h5A5A1234;
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 0 && i <= 9) sb.push_back(model(0, 2, 0, 32'h40, 32'h0, 1, 32'h5A5A1234));
            REQ = (i <= 10);
            BUS_ACK = BUS_REQ;
            if (BUS_REQ) reqs++;
            @(negedge CLK);
        end
        BUS_ACK = 0;
        chk("held_req_accesses", reqs, 4);
        chk("held_req_all_done", sb.size(), 0);

        // reset during a stalled access
        chk("rdata_nonzero_before_reset", RDATA != 0, 1);
        REQ = 1; WE = 0; SIZE = 2; ADDR = 32'h200;
        @(negedge CLK);
        REQ = 0;
        @(negedge CLK);
        RST_N = 0;
        @(negedge CLK);
        chk("midreset_bus_req", BUS_REQ, 0);
        chk("midreset_busy", BUSY, 0);
        chk("midreset_rdata", RDATA, 0);
        chk("midreset_done", DONE, 0);
        model_rdata = 0;
        RST_N = 1;
        repeat (8) @(negedge CLK);
        chk("no_done_after_reset", sb.size(), 0);
        txn(0, 0, 1, 32'h1, 32'h0, 1, 32'h0000EE00);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit sitting directly downstream of the core's memory-access stage: it takes one data-memory request per instruction (address, size, signedness, store data) and drives a word-wide, byte-enabled data bus with a request/acknowledge handshake. It performs little-endian byte-lane steering, store-data replication, load extraction with sign/zero extension, alignment checking and bus timeout. One transaction is in flight at a time, matching the multicycle core's MEMORY state.

## Interface
- WAIT_MAX, default 255: maximum cycles BUS_REQ is held without BUS_ACK before the access is aborted (1..65535).

- RST_N  in  1  reset, synchronous, active-low
- CLK  in  1  clock
- REQ  in  1  start access; sampled only in IDLE
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- UNS  in  1  load zero-extends when 1, sign-extends when 0
- ADDR  in  32  byte address
- WDATA  in  32  store data, value in low bits
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle completion pulse
- RDATA  out  32  extended load result, valid from DONE until the next load's DONE
- MISALIGN  out  1  with DONE: alignment/size fault, no bus access made
- ERR  out  1  with DONE: bus timeout
- BUS_REQ  out  1  bus request, held until ack
- BUS_WE  out  1  bus write
- BUS_ADDR  out  32  {ADDR[31:2], 2'b00}
- BUS_BE  out  4  byte enables
- BUS_WDATA  out  32  lane-replicated store data
- BUS_ACK  in  1  bus completes the access in this cycle
- BUS_RDATA  in  32  read word, valid when BUS_ACK

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: REQ=1 latches WE, SIZE, UNS, ADDR[1:0], WDATA and the bus fields.
  - Aligned: go to ACCESS.
  - Misaligned (SIZE=1 with ADDR[0]=1; SIZE=2 with ADDR[1:0]≠0; SIZE=3): go to RESP with MISALIGN set; BUS_REQ never asserts.
- ACCESS: BUS_REQ=1 with stable BUS_WE/ADDR/BE/WDATA.
  - BUS_ACK=1: capture BUS_RDATA for a load, then go to RESP.
  - Otherwise increment the wait counter. When the counter reaches WAIT_MAX without ack, drop BUS_REQ and go to RESP with ERR set. RDATA is unchanged.
- RESP: DONE=1 for one cycle, then IDLE.
- BUSY is high in ACCESS and RESP. REQ outside IDLE is ignored.
- Lane rules, k = ADDR[1:0]:
  - byte: BE = 4'b0001<<k, BUS_WDATA = {4{WDATA[7:0]}}
  - half: BE = 4'b0011<<k, BUS_WDATA = {2{WDATA[15:0]}}
  - word: BE = 4'hF, BUS_WDATA = WDATA
- Load extraction:
  - byte = BUS_RDATA[8k+7:8k]
  - half = BUS_RDATA[8k+15:8k]
  - word = BUS_RDATA
  - Byte and half results are extended to 32 bits per UNS.
- Stores leave RDATA unchanged. MISALIGN and ERR are mutually exclusive and low whenever DONE is low.
- BUS_WE, BUS_BE and BUS_WDATA are 0 outside ACCESS.

## Timing
- Reset values: BUSY=0, DONE=0, RDATA=0, MISALIGN=0, ERR=0, BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_BE=0, BUS_WDATA=0; state IDLE, wait counter 0.
- All outputs are registered.
- Aligned access, REQ at cycle 0:
  - BUS_REQ is high from cycle 1.
  - If BUS_ACK arrives at cycle n ≥ 1, DONE and RDATA appear at cycle n+1, and BUS_REQ is low at cycle n+1.
  - Minimum latency REQ→DONE is 2 cycles.
- Misaligned access: DONE and MISALIGN at cycle 1.
- Timeout: with no ack, BUS_REQ is high for exactly WAIT_MAX cycles (1..WAIT_MAX); DONE and ERR at cycle WAIT_MAX+1.
- BUS_ACK in the last wait cycle counts as success.
- BUS_ACK while BUS_REQ=0 is ignored.
- REQ in the same cycle as DONE is ignored. The next REQ is accepted the cycle after DONE (back-to-back period = latency + 1).
- RST_N=0 mid-transaction: at the next edge all outputs take reset values and no DONE is produced.

## Test plan
- Load byte, ADDR=0x103, UNS=0; ack in cycle 1 with BUS_RDATA=0x80AABBCC -> BUS_ADDR=0x100, BE=4'b1000, DONE at cycle 2, RDATA=0xFFFFFF80; UNS=1 -> RDATA=0x00000080.
- Store half, ADDR=0x22, WDATA=0x1234ABCD; ack after 3 wait cycles -> BUS_WE=1, BE=4'b1100, BUS_WDATA=0xABCDABCD, DONE at cycle 5, RDATA unchanged.
- Load word, ADDR=0x41 -> BUS_REQ stays 0, DONE and MISALIGN at cycle 1; likewise SIZE=3 at ADDR=0x40.
- WAIT_MAX=4, load word at 0x200, no ack -> BUS_REQ high in cycles 1-4, DONE and ERR at cycle 5; ack at cycle 4 instead -> DONE at cycle 5 with ERR=0.
- REQ held high continuously, ack always immediate -> one DONE every 3 cycles; REQ during BUSY produces no extra access.
- RST_N low at cycle 2 of a stalled access -> BUS_REQ=0, BUSY=0, RDATA=0 at cycle 3, no DONE afterwards.
